upsp_axis_packer: RTL
=====================

# upsp_axis_packer

Downstream stage of the bicubic upsampling IP: consumes the 24-bit RGB pixel stream on the IP's master AXI-Stream output and packs it into dense 32-bit words for the S2MM DMA (4 pixels -> 3 words). It tracks line and frame position against the configured destination geometry. It regenerates frame-level tuser/tlast for the DMA, and flags malformed lines and frames with sticky error bits.

## Interface
Parameters:
- DST_IMG_WIDTH, 3840, pixels per line; must be a multiple of 4.
- DST_IMG_HEIGHT, 2160, lines per frame.
- PIXEL_WIDTH, 24, input beat width; fixed at 24.
- OUT_DATA_WIDTH, 32, output word width; fixed at 32.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tvalid  in  1  pixel valid.
- s_axis_tready  out  1  pixel accept.
- s_axis_tdata  in  24  pixel {R,G,B}; byte 0 = bits [7:0].
- s_axis_tlast  in  1  end of line.
- s_axis_tuser  in  1  start of frame.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tdata  out  32  packed word, little-endian byte order.
- m_axis_tkeep  out  4  always 4'hF when valid.
- m_axis_tlast  out  1  last word of frame.
- m_axis_tuser  out  1  first word of frame.
- frame_done  out  1  one-cycle pulse on handshake of the word carrying m_axis_tlast.
- err_eol_early  out  1  sticky: s_axis_tlast with col < DST_IMG_WIDTH-1.
- err_eol_late  out  1  sticky: no s_axis_tlast at col == DST_IMG_WIDTH-1.
- err_sof  out  1  sticky: s_axis_tuser at a position other than row 0, col 0.

## Operation
- Packing phase counter ph (0..3). Residual register holds 0-3 bytes.
- ph0: store p[23:0]; no output.
- ph1: emit {p[7:0], res[23:0]}; store p[23:8].
- ph2: emit {p[15:0], res[15:0]}; store p[23:16].
- ph3: emit {p[23:0], res[7:0]}; ph -> 0.
- Position counters: col 0..DST_IMG_WIDTH-1, row 0..DST_IMG_HEIGHT-1.
- col wraps at line end; row increments at line end and wraps after the last line.
- Line end is col == DST_IMG_WIDTH-1 OR an accepted s_axis_tlast, whichever comes first.
- Early tlast:
  - set err_eol_early;
  - drop residual bytes; the pixel is not emitted unless it completes a word;
  - ph -> 0, col -> 0, row advances.
- Missing tlast at col == DST_IMG_WIDTH-1: set err_eol_late; treat the beat as a line end.
- Accepted s_axis_tuser:
  - counters and ph resync to 0 before the beat is packed; prior residual is dropped;
  - set err_sof if (row,col) != (0,0);
  - the next emitted word carries m_axis_tuser = 1.
- m_axis_tuser is also set on the first word after reset or after a frame wrap.
- m_axis_tlast = 1 on the word completed by pixel (DST_IMG_HEIGHT-1, DST_IMG_WIDTH-1).
- Sticky errors:
  - cleared on the cycle after a tuser beat is accepted at (0,0);
  - otherwise held until reset;
  - a simultaneous set and clear resolves to set.

## Timing
- Single output register stage; s_axis_tready = !m_axis_tvalid || m_axis_tready.
- This applies in every phase, including ph0, which emits nothing.
- Latency: a word completed by the pixel accepted in cycle N is valid in cycle N+1.
- Throughput: 1 pixel/cycle sustained; the output is idle 1 cycle in every 4.
- Output stability: while m_axis_tvalid && !m_axis_tready, tdata/tlast/tuser/tkeep are held stable and the input stalls.
- m_axis_tvalid drops the cycle after handshake unless a new word is loaded in the same cycle.
- frame_done is asserted in the same cycle as the tlast handshake.
- Reset: all outputs 0 (s_axis_tready = 1 one cycle after deassertion), counters/ph/residual 0, errors 0.
- Reset mid-frame discards any held word and residual.

## Test plan
Run with DST_IMG_WIDTH=8, DST_IMG_HEIGHT=2 unless noted.
- Pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A, tuser on the first -> words 0x04030201, 0x08070605, 0x0C0B0A09; first word tuser=1; no errors.
- Full frame of 16 pixels with correct tlast at col 7 -> 12 words; m_axis_tlast and frame_done only on word 12; second frame's first word has tuser=1.
- Random m_axis_tready (30% low) over 3 frames -> output matches the golden byte stream; no word held changes while stalled.
- tlast at col 5 of row 0 -> err_eol_early=1; residual dropped; row 1 packs from ph0.
- No tlast at col 7 -> err_eol_late=1.
- tuser at row 1 col 2 -> err_sof=1; the next word has tuser=1.
- A later clean tuser at (0,0) clears all errors.
- rst_n pulsed low with 2 residual bytes and a stalled word -> all outputs 0 asynchronously; the next frame packs correctly with no leftover bytes.

Source files
------------

// File: rtl/upsp_axis_packer.sv
// Packs a 24-bit RGB AXI-Stream into dense 32-bit words (4 pixels -> 3 words),
// tracks line/frame position and regenerates frame-level tuser/tlast with sticky error flags.
module upsp_axis_packer #(
    parameter int DST_IMG_WIDTH  = 3840,
    parameter int DST_IMG_HEIGHT = 2160,
    parameter int PIXEL_WIDTH    = 24,
    parameter int OUT_DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [PIXEL_WIDTH-1:0]      s_axis_tdata,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tuser,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [OUT_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [OUT_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    output logic                        frame_done,
    output logic                        err_eol_early,
    output logic                        err_eol_late,
    output logic                        err_sof
);

    localparam int CW = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
    localparam int RW = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(DST_IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(DST_IMG_HEIGHT - 1);

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    phase_t                    ph;
    logic [23:0]               res;
    logic [CW-1:0]             col;
    logic [RW-1:0]             row;
    logic                      sof_pending;
    logic                      ready_en;

    logic                      accept;
    logic                      at_origin;
    logic                      sof_beat;
    phase_t                    eff_ph;
    phase_t                    next_ph;
    logic [CW-1:0]             eff_col;
    logic [RW-1:0]             eff_row;
    logic                      last_col;
    logic                      line_end;
    logic                      emit;
    logic [OUT_DATA_WIDTH-1:0] word;
    logic [23:0]               next_res;
    logic                      set_early;
    logic                      set_late;
    logic                      set_sof;
    logic                      clr_err;

    // ready_en keeps the input closed while in reset and for the first cycle after it
    assign s_axis_tready = ready_en && (!m_axis_tvalid || m_axis_tready);
    assign m_axis_tkeep  = {(OUT_DATA_WIDTH/8){m_axis_tvalid}};
    assign frame_done    = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_comb begin
        accept    = s_axis_tvalid && s_axis_tready;
        at_origin = (row == '0) && (col == '0);
        sof_beat  = accept && s_axis_tuser;
        eff_ph    = s_axis_tuser ? PH0 : ph;
        eff_col   = s_axis_tuser ? '0 : col;
        eff_row   = s_axis_tuser ? '0 : row;
        last_col  = (eff_col == LAST_COL);
        line_end  = last_col || s_axis_tlast;
        emit      = accept && (eff_ph != PH0);
        word      = '0;
        next_res  = '0;
        next_ph   = PH0;
        case (eff_ph)
            PH0: begin
                next_res = s_axis_tdata;
                next_ph  = PH1;
            end
            PH1: begin
                word     = {s_axis_tdata[7:0], res};
                next_res = {8'h00, s_axis_tdata[23:8]};
                next_ph  = PH2;
            end
            PH2: begin
                word     = {s_axis_tdata[15:0], res[15:0]};
                next_res = {16'h0000, s_axis_tdata[23:16]};
                next_ph  = PH3;
            end
            default: begin
                word     = {s_axis_tdata, res[7:0]};
                next_res = '0;
                next_ph  = PH0;
            end
        endcase
        // Any line end, early or natural, realigns packing and drops leftover bytes
        if (line_end) begin
            next_ph  = PH0;
            next_res = '0;
        end
        set_early = accept && s_axis_tlast && !last_col;
        set_late  = accept && last_col && !s_axis_tlast;
        set_sof   = sof_beat && !at_origin;
        clr_err   = sof_beat && at_origin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph            <= PH0;
            res           <= '0;
            col           <= '0;
            row           <= '0;
            sof_pending   <= 1'b1;
            ready_en      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            err_eol_early <= 1'b0;
            err_eol_late  <= 1'b0;
            err_sof       <= 1'b0;
        end else begin
            ready_en <= 1'b1;

            if (accept) begin
                ph  <= next_ph;
                res <= next_res;
                if (line_end) begin
                    col <= '0;
                    row <= (eff_row == LAST_ROW) ? '0 : eff_row + 1'b1;
                end else begin
                    col <= eff_col + 1'b1;
                    row <= eff_row;
                end
                // A frame wrap arms tuser for the first word of the next frame
                if (line_end && (eff_row == LAST_ROW))
                    sof_pending <= 1'b1;
                else if (emit)
                    sof_pending <= 1'b0;
                else
                    sof_pending <= sof_pending || s_axis_tuser;
            end

            if (emit) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= word;
                m_axis_tlast  <= (eff_row == LAST_ROW) && last_col;
                m_axis_tuser  <= sof_pending || s_axis_tuser;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            err_eol_early <= set_early || (err_eol_early && !clr_err);
            err_eol_late  <= set_late  || (err_eol_late  && !clr_err);
            err_sof       <= set_sof   || (err_sof       && !clr_err);
        end
    end

endmodule
